// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with per-frame debounce.
// clk/reset(async, low) | row_in: rows (low=pressed) | col_out: one-hot-low
// key_code: last accepted 4*row+col | key_valid: accept pulse | key_held
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 100000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD
  } state_t;

  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    col;
  logic          last;
  logic [15:0]   snap;
  logic [15:0]   snap_n;
  logic          frame_end_q;

  logic          none;
  logic          multi;
  logic          single;
  logic [3:0]    hit;

  state_t        state;
  state_t        state_n;
  logic [3:0]    cand;
  logic [3:0]    cand_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    code_n;
  logic          valid_n;
  logic          held_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  end

  assign last = (dwell == DWELL_LAST);

  // col_out rotates as its own register so the pins
  // never glitch through a decoder when col changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell   <= '0;
      col     <= 2'd0;
      col_out <= 4'b1110;
    end else if (last) begin
      dwell   <= '0;
      col     <= col + 2'd1;
      col_out <= {col_out[2:0], col_out[3]};
    end else begin
      dwell   <= dwell + DW'(1);
    end
  end

  always_comb begin
    snap_n = snap;
    for (int r = 0; r < 4; r++) begin
      snap_n[{2'(r), col}] = ~row_s2[r];
    end
  end

  // Every column rewrites its 4 bits each frame,
  // so the snapshot never needs clearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap        <= 16'h0;
      frame_end_q <= 1'b0;
    end else begin
      if (last) begin
        snap <= snap_n;
      end
      frame_end_q <= last && (col == 2'd3);
    end
  end

  assign none   = (snap == 16'h0);
  assign multi  = |(snap & (snap - 16'd1));
  assign single = !none && !multi;

  always_comb begin
    hit = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        hit = 4'(i);
      end
    end
  end

  assign cnt_inc = cnt + CNT_ONE;

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
    if (frame_end_q) begin
      unique case (state)
        S_IDLE: begin
          if (single) begin
            cand_n = hit;
            if (DEBOUNCE_FRAMES == 1) begin
              code_n  = hit;
              valid_n = 1'b1;
              held_n  = 1'b1;
              cnt_n   = '0;
              state_n = S_HELD;
            end else begin
              cnt_n   = CNT_ONE;
              state_n = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          unique case (1'b1)
            single && (hit == cand): begin
              if (cnt_inc == CNT_DONE) begin
                code_n  = cand;
                valid_n = 1'b1;
                held_n  = 1'b1;
                cnt_n   = '0;
                state_n = S_HELD;
              end else begin
                cnt_n = cnt_inc;
              end
            end
            single && (hit != cand): begin
              cand_n = hit;
              cnt_n  = CNT_ONE;
            end
            default: begin
              cnt_n   = '0;
              state_n = S_IDLE;
            end
          endcase
        end
        S_HELD: begin
          if (none) begin
            if (cnt_inc == CNT_DONE) begin
              held_n  = 1'b0;
              cnt_n   = '0;
              state_n = S_IDLE;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            // Any key activity restarts the release count.
            cnt_n = '0;
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cand      <= 4'd0;
      cnt       <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: phase table + scoreboard bench for keypad_scanner.
// Matrix model drives rows from pressed keys and the active column.
module tb_keypad_scanner;

  localparam int SC = 4;
  localparam int DF = 3;
  localparam int FR = 4 * SC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_CYCLES(SC),
    .DEBOUNCE_FRAMES(DF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_in(row_in),
    .col_out(col_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) begin
          row_in[r] = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          pulses;
    logic [3:0]  code;
    logic        held;
  } phase_t;

  typedef struct {
    int         at;
    int         pulses;
    logic [3:0] code;
    logic       held;
    int         id;
  } exp_t;

  exp_t   sb[$];
  exp_t   e;
  phase_t ph[17];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      seen = 0;
    end else if (key_valid) begin
      seen++;
    end
    if (sb.size() > 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      chk($sformatf("ph%0d_pulses", e.id), seen, e.pulses);
      chk($sformatf("ph%0d_code", e.id), key_code, e.code);
      chk($sformatf("ph%0d_held", e.id), key_held, e.held);
      seen = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  int         np;
  int         at_edge;
  logic [3:0] pc;
  logic [3:0] exp_col;

  initial begin
    ph[0]  = '{16'h0000, 2, 0, 4'd0,  1'b0};
    ph[1]  = '{16'h0040, 6, 1, 4'd6,  1'b1};
    ph[2]  = '{16'h0000, 3, 0, 4'd6,  1'b0};
    ph[3]  = '{16'h0001, 2, 0, 4'd6,  1'b0};
    ph[4]  = '{16'h0000, 1, 0, 4'd6,  1'b0};
    ph[5]  = '{16'h0001, 3, 1, 4'd0,  1'b1};
    ph[6]  = '{16'h0000, 3, 0, 4'd0,  1'b0};
    ph[7]  = '{16'h8002, 5, 0, 4'd0,  1'b0};
    ph[8]  = '{16'h0000, 1, 0, 4'd0,  1'b0};
    ph[9]  = '{16'h0800, 3, 1, 4'd11, 1'b1};
    ph[10] = '{16'h0810, 2, 0, 4'd11, 1'b1};
    ph[11] = '{16'h0010, 4, 0, 4'd11, 1'b1};
    ph[12] = '{16'h0000, 2, 0, 4'd11, 1'b1};
    ph[13] = '{16'h0010, 1, 0, 4'd11, 1'b1};
    ph[14] = '{16'h0000, 3, 0, 4'd11, 1'b0};
    ph[15] = '{16'h0010, 3, 1, 4'd4,  1'b1};
    ph[16] = '{16'h0000, 3, 0, 4'd4,  1'b0};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst0_col", col_out, 4'b1110);
    chk("rst0_valid", key_valid, 0);
    chk("rst0_held", key_held, 0);
    chk("rst0_code", key_code, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      exp_col = ~(4'd1 << (i / 4));
      chk($sformatf("col_step%0d", i), col_out, exp_col);
      @(negedge clk);
    end

    foreach (ph[i]) begin
      keys = ph[i].keys;
      repeat (ph[i].frames * FR) @(negedge clk);
      sb.push_back('{cyc + 2, ph[i].pulses, ph[i].code,
                     ph[i].held, i});
    end
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    keys = 16'h2000;
    repeat (5 * FR) @(negedge clk);
    chk("pre_rst_held", key_held, 1);
    chk("pre_rst_code", key_code, 13);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst1_col", col_out, 4'b1110);
    chk("rst1_valid", key_valid, 0);
    chk("rst1_held", key_held, 0);
    chk("rst1_code", key_code, 0);

    keys = 16'h0200;
    @(negedge clk);
    reset = 1'b1;
    repeat (2 * FR + 5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst2_valid", key_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    np = 0;
    at_edge = -1;
    pc = 4'd0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (key_valid) begin
        np++;
        at_edge = k;
        pc = key_code;
      end
    end
    chk("rst2_pulses", np, 1);
    chk("rst2_pulse_edge", at_edge, 3 * FR + 1);
    chk("rst2_code", pc, 9);
    chk("rst2_held", key_held, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 passive matrix keypad, such as the Pmod KYPD, by driving one column low at a time and reading the rows. It debounces the result per scan frame and reports each press as a 4-bit key code with a one-cycle valid strobe and a held level. It is the input-side counterpart of the multiplexed seven-segment display path: it time-multiplexes the keypad the way the display controller time-multiplexes digits. It sits between the board pins and the counter/datapath logic in the top level.

## Interface
- SCAN_CYCLES, default 100000: clk cycles each column is driven (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_FRAMES, default 4: consecutive identical frames needed to accept a press or a release; minimum 1.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- row_in  input  4  keypad rows; active-low with external pull-ups; asynchronous to clk.
- col_out  output  4  column drive; active-low one-hot, exactly one bit low at all times.
- key_code  output  4  code of the last accepted key: 4*row + col.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high from press acceptance until release acceptance.

## Operation
- row_in passes through a 2-flop synchronizer before any use.
- Column sequencer:
  - Dwell counter runs 0..SCAN_CYCLES-1.
  - Column index runs 0,1,2,3,0,…
  - col_out = ~(1 << col), updated on the edge where the dwell counter wraps.
- Sampling:
  - Synchronized rows are sampled on the last dwell cycle of each column, into 4 bits of a 16-bit snapshot.
  - A row bit that is 0 marks key (row, col) as pressed.
- Frame:
  - One frame is 4 columns = 4*SCAN_CYCLES cycles.
  - The frame ends at the column-3 sample edge.
  - The snapshot is classified as NONE (no bits), SINGLE(k) (exactly one bit), or MULTI (two or more bits).
- State machine (evaluated once per frame end; registers: cand[3:0], cnt):
  - IDLE
    - SINGLE(k): cand=k, cnt=1, go to DEBOUNCE. If DEBOUNCE_FRAMES==1, accept immediately instead.
    - NONE or MULTI: stay in IDLE.
  - DEBOUNCE
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_FRAMES, accept: key_code=cand, key_valid pulse, key_held=1, cnt=0, go to HELD.
    - SINGLE(other k): cand=k, cnt=1.
    - NONE or MULTI: go to IDLE.
  - HELD
    - NONE: cnt+1. When cnt reaches DEBOUNCE_FRAMES, key_held=0, go to IDLE.
    - SINGLE(any) or MULTI: cnt=0, stay in HELD. No new key is reported until a full release is accepted.
- key_code holds its value after release; it changes only on acceptance.
- Simultaneous keys (MULTI) are never reported. This also covers ghosting from 3-key patterns.

## Timing
- Reset values: col_out=4'b1110, key_code=0, key_valid=0, key_held=0, state IDLE, cand=0, cnt=0, dwell=0, col=0, synchronizer flops=1 (all released).
- Reset is asynchronous: outputs take their reset values immediately on reset low, including mid-frame or mid-debounce. The first frame after release starts at column 0, dwell 0.
- Row-to-sample latency: a row change is seen by the sampler 2 cycles later. Sampling on the last dwell cycle gives at least 2 cycles of settle after a column change when SCAN_CYCLES≥4.
- Acceptance latency:
  - key_valid, key_held and key_code update together on the clk edge after the final column-3 sample edge of the DEBOUNCE_FRAMES-th matching frame.
  - key_valid is high for exactly 1 cycle.
- Release latency: key_held falls on the clk edge after the column-3 sample edge of the DEBOUNCE_FRAMES-th consecutive NONE frame.
- Counters wrap at the parameter limits. cnt never exceeds DEBOUNCE_FRAMES.

## Test plan
Bench settings: SCAN_CYCLES=4, DEBOUNCE_FRAMES=3, so one frame is 16 cycles. The keypad model drives row_in[r]=0 whenever col_out[c]=0 and key (r,c) is pressed.

- Reset: assert reset=0 mid-scan → col_out=1110, key_valid=0, key_held=0, key_code=0 immediately. Release reset → col_out steps 1110→1101→1011→0111 every 4 cycles.
- Clean press: press (row1, col2) for 6 frames → exactly one key_valid pulse with key_code=6, one cycle after the 3rd frame end. key_held=1 from then on.
- Release: release the key from the previous scenario → key_held=0 after 3 NONE frames. No key_valid pulse. key_code stays 6.
- Bounce: press (0,0) for 2 frames, release 1 frame, press 3 frames → a single pulse with key_code=0, only after the final 3 consecutive frames.
- Multi-key and held-block cases:
  - Press (0,1) and (3,3) together for 5 frames → no pulse.
  - While (2,3) is held (code 11), add and then swap to (1,0) → no second pulse until 3 NONE frames occur.
- Reset mid-debounce: assert reset after 2 matching frames, then hold the key → pulse occurs only after 3 full frames from reset release.
